// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run controller for the serial Moore pattern detector with programmable pattern and match counting
module seq_match_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [MAX_LEN-1:0] pattern, hist, hist_n, mask;
  logic [MAX_LEN:0]   mask_w;
  logic [3:0]         len, fill, fill_n;
  logic               overlap, hit, len_ok;
  logic [CNT_W-1:0]   target, cnt_n;
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], in};
    fill_n = fill + 4'(fill != 4'(MAX_LEN));
    mask_w = ({{MAX_LEN{1'b0}}, 1'b1} << len) - 1'b1;
    mask   = mask_w[MAX_LEN-1:0];
    hit    = (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
    cnt_n  = match_count + CNT_W'(match_count != '1);
    len_ok = (cfg_len != 4'd0) && (cfg_len <= 4'(MAX_LEN));
  end
  always_ff @(posedge clk) begin
    match   <= 1'b0;
    cfg_err <= 1'b0;
    if (rst) begin
      state       <= IDLE;
      pattern     <= MAX_LEN'(5'b11011);
      len         <= 4'd5;
      overlap     <= 1'b1;
      target      <= '0;
      hist        <= '0;
      fill        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      if (cfg_we && state == IDLE) begin
        if (len_ok) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          target  <= cfg_target;
        end else cfg_err <= 1'b1;
      end
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start && state != RUN) begin
        state       <= RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        hist        <= '0;
        fill        <= '0;
        match_count <= '0;
      end else if (state == RUN && in_valid) begin
        hist <= hist_n;
        fill <= (hit && !overlap) ? 4'd0 : fill_n;
        if (hit) begin
          match       <= 1'b1;
          match_count <= cnt_n;
          if (target != '0 && cnt_n == target) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed bench with a queue of expected match pulses for seq_match_ctrl
module tb_seq_match_ctrl;
  logic       clk = 0, rst = 1, cfg_we = 0, cfg_overlap = 1, start = 0, abort = 0, in_valid = 0, in = 0;
  logic [7:0] cfg_pattern = 0, cfg_target = 0;
  logic [3:0] cfg_len = 0;
  logic       busy, match, done, cfg_err;
  logic [7:0] match_count;
  int checks = 0, failures = 0;
  logic exp_q[$];

  seq_match_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .in_valid(in_valid), .in(in), .busy(busy), .match(match), .match_count(match_count),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] t);
    cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
    tick();
    cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic send(input logic b, input logic m);
    in_valid = 1; in = b;
    exp_q.push_back(m);
    tick();
    in_valid = 0;
    chk("match", match, exp_q.pop_front());
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("match_gap", match, 0);
    end
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_match", match, 0);

    do_start();
    chk("t1_busy", busy, 1);
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,1);
    send(0,0); send(1,0); send(1,1);
    chk("t1_count", match_count, 2);
    chk("t1_busy2", busy, 1);
    chk("t1_done", done, 0);

    do_abort();
    cfg(8'b11011, 5, 0, 0);
    do_start();
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,1);
    send(0,0); send(1,0); send(1,0);
    chk("t2_count", match_count, 1);

    do_abort();
    cfg(8'b11011, 5, 1, 2);
    do_start();
    send(1,0); send(1,0); send(0,0);
    gap(3);
    send(1,0); send(1,1); send(0,0); send(1,0); send(1,1);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,0);
    chk("t3_count", match_count, 2);
    chk("t3_done_hold", done, 1);

    do_abort();
    chk("t4_done_clr", done, 0);
    cfg(8'b101, 0, 1, 0);
    chk("t4_err_len0", cfg_err, 1);
    tick();
    chk("t4_err_clear", cfg_err, 0);
    cfg(8'b101, 9, 1, 0);
    chk("t4_err_len9", cfg_err, 1);
    cfg(8'b11011, 5, 1, 0);
    chk("t4_err_ok", cfg_err, 0);
    do_start();
    cfg(8'b101, 3, 1, 0);
    chk("t4_err_run", cfg_err, 0);
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,1);
    chk("t4_count", match_count, 1);

    do_abort();
    do_start();
    send(1,0); send(1,0); send(0,0); send(1,0);
    abort = 1;
    send(1,0);
    abort = 0;
    chk("t5_count", match_count, 0);
    chk("t5_busy", busy, 0);
    do_start();
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,1);
    chk("t5_count2", match_count, 1);

    do_abort();
    cfg(8'b1, 1, 1, 0);
    do_start();
    for (int i = 0; i < 260; i++) send(1,1);
    chk("t6_sat", match_count, 255);
    send(0,0);
    chk("t6_busy", busy, 1);

    rst = 1;
    tick();
    rst = 0;
    chk("t7_rst_count", match_count, 0);
    chk("t7_rst_busy", busy, 0);
    do_start();
    send(1,0); send(1,0); send(0,0); send(1,0); send(1,1);
    chk("t7_count", match_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
